// File: rtl/dpwm_sequencer.sv
// Purpose : start/stop/fault sequencer driving the DPWM configuration inputs
//           (dead time, arm, soft-start ramp, soft-stop ramp, latched fault trip).
// Latency : all outputs registered; every decision is visible 1 cycle after its cause.
// Backpressure: none; level/pulse inputs are sampled every cycle, ramps advance on period_end.
//
// Ports
//   CLOCK_50       system clock
//   reset          synchronous active-high reset
//   start/stop     run request / soft-stop request (stop dominates start)
//   fault          trip input, fault_clr clears the latched trip once fault is low
//   period_end     1-cycle pulse from the DPWM at counter wrap; paces ARM and ramps
//   tgt_*          requested duty / frequency / dead-time codes
//   duty_8b, freq_4b, dt1_3b, dt2_3b, EN   configuration sent to the PWM datapath
//   state_o        FSM state (IDLE=0 ARM=1 RAMP_UP=2 RUN=3 RAMP_DN=4 FAULT=5)
//   fault_latched  sticky trip flag
module dpwm_sequencer #(
    parameter int unsigned RAMP_PERIODS = 4,
    parameter logic [7:0]  DUTY_MAX     = 8'd160,
    parameter int unsigned ARM_PERIODS  = 2
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       fault,
    input  logic       fault_clr,
    input  logic       period_end,
    input  logic [7:0] tgt_duty_8b,
    input  logic [3:0] tgt_freq_4b,
    input  logic [2:0] tgt_dt1_3b,
    input  logic [2:0] tgt_dt2_3b,
    output logic [7:0] duty_8b,
    output logic [3:0] freq_4b,
    output logic [2:0] dt1_3b,
    output logic [2:0] dt2_3b,
    output logic       EN,
    output logic [2:0] state_o,
    output logic       fault_latched
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        RAMP_UP = 3'd2,
        RUN     = 3'd3,
        RAMP_DN = 3'd4,
        FAULT   = 3'd5
    } state_t;

    // One shared period counter: it is cleared on every state entry, so ARM and
    // the ramp states never need their counts at the same time.
    localparam int unsigned CNT_MAX = (ARM_PERIODS > RAMP_PERIODS) ? ARM_PERIODS : RAMP_PERIODS;
    localparam int unsigned CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

    localparam logic [CW-1:0] ARM_LAST   = CW'(ARM_PERIODS - 1);
    localparam logic [CW-1:0] RAMP_LAST  = CW'(RAMP_PERIODS - 1);
    // Count value loaded when a period_end coincides with a state entry that it
    // did not cause: the pulse belongs to the new state's count.
    localparam logic [CW-1:0] ARM_FIRST  = (ARM_PERIODS > 1)  ? CW'(1) : '0;
    localparam logic [CW-1:0] RAMP_FIRST = (RAMP_PERIODS > 1) ? CW'(1) : '0;

    localparam logic [3:0] FREQ_DEFAULT = 4'b0110;
    localparam logic [3:0] FREQ_LIMIT   = 4'd10;
    localparam logic [2:0] DT_DEFAULT   = 3'b001;

    state_t        state, state_nxt;
    logic [7:0]    duty, duty_nxt;
    logic [3:0]    freq, freq_nxt;
    logic [2:0]    dt1, dt1_nxt;
    logic [2:0]    dt2, dt2_nxt;
    logic          en, en_nxt;
    logic          flt, flt_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    logic [7:0]    tgt_eff;
    logic [3:0]    freq_safe;
    logic          run_req;
    logic          ramp_step;
    logic          arm_done;
    logic [CW-1:0] arm_entry;
    logic [CW-1:0] ramp_entry;
    logic [7:0]    duty_toward;

    function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
        if (cur < tgt) begin
            return cur + 8'd1;
        end else if (cur > tgt) begin
            return cur - 8'd1;
        end else begin
            return cur;
        end
    endfunction

    assign tgt_eff     = (tgt_duty_8b > DUTY_MAX) ? DUTY_MAX : tgt_duty_8b;
    assign freq_safe   = (tgt_freq_4b > FREQ_LIMIT) ? FREQ_DEFAULT : tgt_freq_4b;
    assign run_req     = start && !stop;
    assign ramp_step   = period_end && (cnt == RAMP_LAST);
    assign arm_done    = period_end && (cnt == ARM_LAST);
    assign arm_entry   = period_end ? ARM_FIRST : '0;
    assign ramp_entry  = period_end ? RAMP_FIRST : '0;
    // duty never exceeds tgt_eff on the way up, so it stays within DUTY_MAX
    assign duty_toward = step_toward(duty, tgt_eff);

    always_comb begin
        state_nxt = state;
        duty_nxt  = duty;
        freq_nxt  = freq;
        dt1_nxt   = dt1;
        dt2_nxt   = dt2;
        en_nxt    = en;
        flt_nxt   = flt;
        cnt_nxt   = cnt;

        unique case (state)
            IDLE: begin
                en_nxt   = 1'b0;
                duty_nxt = 8'd0;
                freq_nxt = freq_safe;
                dt1_nxt  = tgt_dt1_3b;
                dt2_nxt  = tgt_dt2_3b;
                cnt_nxt  = '0;
                if (run_req) begin
                    state_nxt = ARM;
                    en_nxt    = 1'b1;
                    cnt_nxt   = arm_entry;
                end
            end

            // Dead time is applied with EN high and zero duty for a few periods.
            ARM: begin
                if (!run_req) begin
                    state_nxt = RAMP_DN;
                    cnt_nxt   = ramp_entry;
                end else if (arm_done) begin
                    state_nxt = RAMP_UP;
                    cnt_nxt   = '0;
                end else if (period_end) begin
                    cnt_nxt = cnt + CW'(1);
                end
            end

            RAMP_UP: begin
                if (!run_req) begin
                    state_nxt = RAMP_DN;
                    cnt_nxt   = ramp_entry;
                end else if (ramp_step) begin
                    cnt_nxt  = '0;
                    duty_nxt = duty_toward;
                    if (duty_toward == tgt_eff) begin
                        state_nxt = RUN;
                    end
                end else if (period_end) begin
                    cnt_nxt = cnt + CW'(1);
                end
            end

            RUN: begin
                if (!run_req) begin
                    state_nxt = RAMP_DN;
                    cnt_nxt   = ramp_entry;
                end else if (period_end) begin
                    cnt_nxt = ramp_step ? '0 : cnt + CW'(1);
                    if (ramp_step) begin
                        duty_nxt = duty_toward;
                    end
                    // Frequency/dead-time changes only land on a period boundary, and
                    // are held off while the requested duty is out of range.
                    if (tgt_duty_8b <= DUTY_MAX) begin
                        freq_nxt = freq_safe;
                        dt1_nxt  = tgt_dt1_3b;
                        dt2_nxt  = tgt_dt2_3b;
                    end
                end
            end

            RAMP_DN: begin
                if (run_req) begin
                    state_nxt = RAMP_UP;
                    cnt_nxt   = ramp_entry;
                end else if (duty == 8'd0) begin
                    // duty reached 0 on the previous step; drop EN one cycle later
                    state_nxt = IDLE;
                    en_nxt    = 1'b0;
                    cnt_nxt   = '0;
                end else if (ramp_step) begin
                    cnt_nxt  = '0;
                    duty_nxt = duty - 8'd1;
                end else if (period_end) begin
                    cnt_nxt = cnt + CW'(1);
                end
            end

            FAULT: begin
                en_nxt   = 1'b0;
                duty_nxt = 8'd0;
                cnt_nxt  = '0;
                if (fault_clr) begin
                    state_nxt = IDLE;
                    flt_nxt   = 1'b0;
                end
            end

            default: begin
                state_nxt = IDLE;
                en_nxt    = 1'b0;
                duty_nxt  = 8'd0;
                cnt_nxt   = '0;
            end
        endcase

        // Trip overrides every state decision above, including a pending fault_clr.
        if (fault) begin
            state_nxt = FAULT;
            en_nxt    = 1'b0;
            duty_nxt  = 8'd0;
            flt_nxt   = 1'b1;
            cnt_nxt   = '0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state <= IDLE;
            duty  <= 8'd0;
            freq  <= FREQ_DEFAULT;
            dt1   <= DT_DEFAULT;
            dt2   <= DT_DEFAULT;
            en    <= 1'b0;
            flt   <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            duty  <= duty_nxt;
            freq  <= freq_nxt;
            dt1   <= dt1_nxt;
            dt2   <= dt2_nxt;
            en    <= en_nxt;
            flt   <= flt_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign duty_8b       = duty;
    assign freq_4b       = freq;
    assign dt1_3b        = dt1;
    assign dt2_3b        = dt2;
    assign EN            = en;
    assign state_o       = state;
    assign fault_latched = flt;

endmodule

// File: tb/tb_dpwm_sequencer.sv
// Purpose : self-checking bench for dpwm_sequencer (RAMP_PERIODS=4, DUTY_MAX=160, ARM_PERIODS=2).
// Latency : outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a; expected duty values are queued when a pulse is driven and popped after it.
module tb_dpwm_sequencer;

    localparam int RP = 4;

    logic       CLOCK_50 = 1'b0;
    logic       reset, start, stop, fault, fault_clr, period_end;
    logic [7:0] tgt_duty_8b;
    logic [3:0] tgt_freq_4b;
    logic [2:0] tgt_dt1_3b, tgt_dt2_3b;
    logic [7:0] duty_8b;
    logic [3:0] freq_4b;
    logic [2:0] dt1_3b, dt2_3b;
    logic       EN;
    logic [2:0] state_o;
    logic       fault_latched;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];

    always #10 CLOCK_50 = ~CLOCK_50;

    dpwm_sequencer #(
        .RAMP_PERIODS (4),
        .DUTY_MAX     (8'd160),
        .ARM_PERIODS  (2)
    ) dut (
        .CLOCK_50      (CLOCK_50),
        .reset         (reset),
        .start         (start),
        .stop          (stop),
        .fault         (fault),
        .fault_clr     (fault_clr),
        .period_end    (period_end),
        .tgt_duty_8b   (tgt_duty_8b),
        .tgt_freq_4b   (tgt_freq_4b),
        .tgt_dt1_3b    (tgt_dt1_3b),
        .tgt_dt2_3b    (tgt_dt2_3b),
        .duty_8b       (duty_8b),
        .freq_4b       (freq_4b),
        .dt1_3b        (dt1_3b),
        .dt2_3b        (dt2_3b),
        .EN            (EN),
        .state_o       (state_o),
        .fault_latched (fault_latched)
    );

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    // Two idle cycles, then one period_end cycle; returns with the pulse's effect visible.
    task automatic pulse();
        tick();
        tick();
        period_end = 1'b1;
        tick();
        period_end = 1'b0;
    endtask

    task automatic test_reset();
        logic [22:0] got, want;
        reset = 1'b1;
        tick();
        tick();
        got  = {state_o, duty_8b, freq_4b, dt1_3b, dt2_3b, EN, fault_latched};
        want = {3'd0, 8'd0, 4'd6, 3'd1, 3'd1, 1'b0, 1'b0};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL reset_values: got %h want %h", got, want);
        end
        reset = 1'b0;
        tick();
        checks++;
        if ({freq_4b, dt1_3b, dt2_3b} !== {4'd9, 3'd5, 3'd3}) begin
            errors++;
            $display("FAIL idle_track: got freq %0d dt1 %0d dt2 %0d want 9 5 3", freq_4b, dt1_3b, dt2_3b);
        end
        tgt_freq_4b = 4'd13;
        tick();
        checks++;
        if (freq_4b !== 4'd6) begin
            errors++;
            $display("FAIL idle_freq13: got %0d want 6", freq_4b);
        end
        tgt_freq_4b = 4'd10;
        tick();
        checks++;
        if (freq_4b !== 4'd10) begin
            errors++;
            $display("FAIL idle_freq10: got %0d want 10", freq_4b);
        end
        tgt_freq_4b = 4'd6;
        tgt_dt1_3b  = 3'd1;
        tgt_dt2_3b  = 3'd1;
        tick();
    endtask

    task automatic test_soft_start();
        logic [7:0] exp_d;
        tgt_duty_8b = 8'd80;
        start       = 1'b1;
        tick();
        checks++;
        if ({state_o, EN, duty_8b} !== {3'd1, 1'b1, 8'd0}) begin
            errors++;
            $display("FAIL arm_entry: got state %0d EN %0d duty %0d want 1 1 0", state_o, EN, duty_8b);
        end
        pulse();
        checks++;
        if (state_o !== 3'd1) begin
            errors++;
            $display("FAIL arm_hold: got state %0d want 1", state_o);
        end
        pulse();
        checks++;
        if (state_o !== 3'd2) begin
            errors++;
            $display("FAIL arm_done: got state %0d want 2", state_o);
        end
        for (int k = 1; k <= 80 * RP; k++) begin
            if (k % RP == 0) exp_q.push_back(8'(k / RP));
            pulse();
            if (k % RP == 0) begin
                exp_d = exp_q.pop_front();
                checks++;
                if (duty_8b !== exp_d) begin
                    errors++;
                    $display("FAIL ramp_up pulse %0d: got duty %0d want %0d", k, duty_8b, exp_d);
                end
            end
        end
        checks++;
        if (state_o !== 3'd3) begin
            errors++;
            $display("FAIL run_entry: got state %0d want 3", state_o);
        end
    endtask

    task automatic test_saturate();
        logic [7:0] exp_d, prev_d, max_d;
        int         max_jump;
        tgt_duty_8b = 8'd200;
        prev_d      = duty_8b;
        max_d       = duty_8b;
        max_jump    = 0;
        for (int k = 1; k <= 80 * RP + 8; k++) begin
            if (k % RP == 0) exp_q.push_back((80 + k / RP > 160) ? 8'd160 : 8'(80 + k / RP));
            pulse();
            if (duty_8b > max_d) max_d = duty_8b;
            if (int'(duty_8b) - int'(prev_d) > max_jump) max_jump = int'(duty_8b) - int'(prev_d);
            prev_d = duty_8b;
            if (k % RP == 0) begin
                exp_d = exp_q.pop_front();
                checks++;
                if (duty_8b !== exp_d) begin
                    errors++;
                    $display("FAIL saturate pulse %0d: got duty %0d want %0d", k, duty_8b, exp_d);
                end
            end
        end
        checks++;
        if (max_d !== 8'd160) begin
            errors++;
            $display("FAIL saturate_max: got max duty %0d want 160", max_d);
        end
        checks++;
        if (max_jump > 1) begin
            errors++;
            $display("FAIL saturate_step: got jump %0d want at most 1", max_jump);
        end
    endtask

    task automatic test_freq_update();
        tgt_duty_8b = 8'd160;
        tgt_freq_4b = 4'd10;
        tgt_dt1_3b  = 3'd4;
        tick();
        tick();
        checks++;
        if (freq_4b !== 4'd6) begin
            errors++;
            $display("FAIL freq_hold: got %0d want 6", freq_4b);
        end
        pulse();
        checks++;
        if ({freq_4b, dt1_3b} !== {4'd10, 3'd4}) begin
            errors++;
            $display("FAIL freq_apply: got freq %0d dt1 %0d want 10 4", freq_4b, dt1_3b);
        end
        tgt_freq_4b = 4'd13;
        tick();
        checks++;
        if (freq_4b !== 4'd10) begin
            errors++;
            $display("FAIL freq13_hold: got %0d want 10", freq_4b);
        end
        pulse();
        checks++;
        if (freq_4b !== 4'd6) begin
            errors++;
            $display("FAIL freq13_apply: got %0d want 6", freq_4b);
        end
        checks++;
        if ({state_o, duty_8b} !== {3'd3, 8'd160}) begin
            errors++;
            $display("FAIL freq_run: got state %0d duty %0d want 3 160", state_o, duty_8b);
        end
    endtask

    task automatic test_soft_stop();
        logic [7:0] exp_d;
        stop = 1'b1;
        tick();
        checks++;
        if ({state_o, EN, duty_8b} !== {3'd4, 1'b1, 8'd160}) begin
            errors++;
            $display("FAIL stop_entry: got state %0d EN %0d duty %0d want 4 1 160", state_o, EN, duty_8b);
        end
        for (int k = 1; k <= 160 * RP; k++) begin
            if (k % RP == 0) exp_q.push_back(8'(160 - k / RP));
            pulse();
            if (k % RP == 0) begin
                exp_d = exp_q.pop_front();
                checks++;
                if (duty_8b !== exp_d) begin
                    errors++;
                    $display("FAIL ramp_dn pulse %0d: got duty %0d want %0d", k, duty_8b, exp_d);
                end
            end
        end
        checks++;
        if ({state_o, EN} !== {3'd4, 1'b1}) begin
            errors++;
            $display("FAIL stop_zero: got state %0d EN %0d want 4 1", state_o, EN);
        end
        tick();
        checks++;
        if ({state_o, EN} !== {3'd0, 1'b0}) begin
            errors++;
            $display("FAIL stop_idle: got state %0d EN %0d want 0 0", state_o, EN);
        end
        start = 1'b0;
        tick();
        stop = 1'b0;
        tick();
    endtask

    task automatic test_fault();
        logic [7:0] exp_d;
        tgt_duty_8b = 8'd80;
        start       = 1'b1;
        tick();
        pulse();
        pulse();
        for (int k = 1; k <= 3 * RP; k++) begin
            if (k % RP == 0) exp_q.push_back(8'(k / RP));
            pulse();
            if (k % RP == 0) begin
                exp_d = exp_q.pop_front();
                checks++;
                if (duty_8b !== exp_d) begin
                    errors++;
                    $display("FAIL fault_ramp pulse %0d: got duty %0d want %0d", k, duty_8b, exp_d);
                end
            end
        end
        fault = 1'b1;
        tick();
        checks++;
        if ({state_o, EN, duty_8b, fault_latched} !== {3'd5, 1'b0, 8'd0, 1'b1}) begin
            errors++;
            $display("FAIL fault_trip: got state %0d EN %0d duty %0d latched %0d want 5 0 0 1",
                     state_o, EN, duty_8b, fault_latched);
        end
        fault_clr = 1'b1;
        tick();
        checks++;
        if ({state_o, fault_latched} !== {3'd5, 1'b1}) begin
            errors++;
            $display("FAIL fault_clr_ignored: got state %0d latched %0d want 5 1", state_o, fault_latched);
        end
        fault     = 1'b0;
        fault_clr = 1'b0;
        start     = 1'b0;
        tick();
        checks++;
        if ({state_o, fault_latched} !== {3'd5, 1'b1}) begin
            errors++;
            $display("FAIL fault_sticky: got state %0d latched %0d want 5 1", state_o, fault_latched);
        end
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        checks++;
        if ({state_o, fault_latched, EN} !== {3'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL fault_exit: got state %0d latched %0d EN %0d want 0 0 0", state_o, fault_latched, EN);
        end
    endtask

    task automatic test_reset_mid_ramp();
        logic [7:0]  exp_d;
        logic [22:0] got, want;
        tgt_freq_4b = 4'd9;
        tgt_dt1_3b  = 3'd5;
        tgt_dt2_3b  = 3'd3;
        tgt_duty_8b = 8'd80;
        tick();
        start = 1'b1;
        tick();
        pulse();
        pulse();
        for (int k = 1; k <= 41 * RP; k++) begin
            if (k % RP == 0) exp_q.push_back(8'(k / RP));
            pulse();
            if (k % RP == 0) begin
                exp_d = exp_q.pop_front();
                checks++;
                if (duty_8b !== exp_d) begin
                    errors++;
                    $display("FAIL rst_ramp pulse %0d: got duty %0d want %0d", k, duty_8b, exp_d);
                end
            end
        end
        start = 1'b0;
        tick();
        for (int k = 1; k <= RP; k++) pulse();
        checks++;
        if ({state_o, duty_8b, freq_4b, dt1_3b} !== {3'd4, 8'd40, 4'd9, 3'd5}) begin
            errors++;
            $display("FAIL rampdn_40: got state %0d duty %0d freq %0d dt1 %0d want 4 40 9 5",
                     state_o, duty_8b, freq_4b, dt1_3b);
        end
        start = 1'b1;
        tick();
        checks++;
        if ({state_o, duty_8b} !== {3'd2, 8'd40}) begin
            errors++;
            $display("FAIL rearm: got state %0d duty %0d want 2 40", state_o, duty_8b);
        end
        start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        got  = {state_o, duty_8b, freq_4b, dt1_3b, dt2_3b, EN, fault_latched};
        want = {3'd0, 8'd0, 4'd6, 3'd1, 3'd1, 1'b0, 1'b0};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL reset_mid_ramp: got %h want %h", got, want);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation time budget exceeded");
        $fatal(1, "time budget exceeded");
    end

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        stop        = 1'b0;
        fault       = 1'b0;
        fault_clr   = 1'b0;
        period_end  = 1'b0;
        tgt_duty_8b = 8'd0;
        tgt_freq_4b = 4'd9;
        tgt_dt1_3b  = 3'd5;
        tgt_dt2_3b  = 3'd3;
        test_reset();
        test_soft_start();
        test_saturate();
        test_freq_update();
        test_soft_stop();
        test_fault();
        test_reset_mid_ramp();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
